// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: drives an external 1-bit shifter once per cycle until done.
// Optional sign-fill for right shifts is enabled by defining SHIFT_SEQ_ARITH_EN.
module shift_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AMT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              right,
  input  logic              arith,
  input  logic [AMT_W-1:0]  amount,
  input  logic [DATA_W-1:0] D_in,
  output logic [DATA_W-1:0] D_out,
  output logic              busy,
  output logic              done,
  output logic              sh_en,
  output logic              sh_right,
  output logic [DATA_W-1:0] sh_in,
  input  logic [DATA_W-1:0] sh_out
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   d_out_q, d_out_d;
  logic [AMT_W-1:0]    cnt_q, cnt_d;
  logic                right_q, right_d;
  logic                arith_q, arith_d;
  logic                fill_sign;

`ifdef SHIFT_SEQ_ARITH_EN
  assign fill_sign = right_q & arith_q;
`else
  // arith is still latched so the register state matches the arithmetic build.
  logic unused_arith;
  assign unused_arith = arith_q;
  assign fill_sign    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    d_out_d = d_out_q;
    cnt_d   = cnt_q;
    right_d = right_q;
    arith_d = arith_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          d_out_d = D_in;
          cnt_d   = amount;
          right_d = right;
          arith_d = arith;
          state_d = (amount != '0) ? StShift : StDone;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        d_out_d = sh_out;
        if (fill_sign) begin
          d_out_d[DATA_W-1] = d_out_q[DATA_W-1];
        end
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      d_out_q <= '0;
      cnt_q   <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_out_q <= d_out_d;
      cnt_q   <= cnt_d;
      right_q <= right_d;
      arith_q <= arith_d;
    end
  end

  assign D_out    = d_out_q;
  assign sh_in    = d_out_q;
  assign busy     = (state_q == StShift);
  assign done     = (state_q == StDone);
  assign sh_en    = (state_q == StShift);
  assign sh_right = right_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: request-level reference model plus directed cases.
module tb_shift_sequencer;

  localparam bit ArithEn =
`ifdef SHIFT_SEQ_ARITH_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, right, arith;
  logic [4:0]  amount;
  logic [31:0] D_in, D_out, sh_in, sh_out;
  logic        busy, done, sh_en, sh_right;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  // Stand-in for the combinational 1-bit shifter (zero fill).
  assign sh_out = sh_en ? (sh_right ? (sh_in >> 1) : (sh_in << 1)) : sh_in;

  shift_sequencer #(.DATA_W(32), .AMT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .right   (right),
    .arith   (arith),
    .amount  (amount),
    .D_in    (D_in),
    .D_out   (D_out),
    .busy    (busy),
    .done    (done),
    .sh_en   (sh_en),
    .sh_right(sh_right),
    .sh_in   (sh_in),
    .sh_out  (sh_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int n, input bit r,
                                            input bit a);
    if (!r) return d << n;
    if (a && ArithEn) return $signed(d) >>> n;
    return d >> n;
  endfunction

  // Model: m_k counts cycles since the accepted request (1 = first cycle after acceptance).
  bit          m_valid = 1'b0;
  int          m_k     = 0;
  int          m_n     = 0;
  logic [31:0] m_din   = '0;
  bit          m_right = 1'b0;
  bit          m_arith = 1'b0;

  function automatic bit m_busy();
    return m_valid && (m_k >= 1) && (m_k <= m_n);
  endfunction

  function automatic bit m_done();
    return m_valid && (m_k == m_n + 1);
  endfunction

  function automatic logic [31:0] m_dout();
    int steps;
    if (!m_valid) return 32'h0;
    steps = (m_k - 1 < m_n) ? m_k - 1 : m_n;
    return ref_shift(m_din, steps, m_right, m_arith);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_k     <= 0;
      m_right <= 1'b0;
      m_arith <= 1'b0;
    end else if (start && !m_busy()) begin
      m_valid <= 1'b1;
      m_k     <= 1;
      m_n     <= int'(amount);
      m_din   <= D_in;
      m_right <= right;
      m_arith <= arith;
    end else if (m_valid && m_k < 40) begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, m_busy()});
      check("done", {31'b0, done}, {31'b0, m_done()});
      check("sh_en", {31'b0, sh_en}, {31'b0, m_busy()});
      check("sh_right", {31'b0, sh_right}, {31'b0, m_right});
      check("D_out", D_out, m_dout());
      check("sh_in", sh_in, m_dout());
    end
  end

  task automatic req(input logic [31:0] d, input bit r, input bit a, input int n);
    @(posedge clk); #1;
    D_in = d; right = r; arith = a; amount = 5'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // k0 is the cycle index (relative to acceptance) of the next negedge.
  task automatic wait_done(input string name, input int k0, input int exp_lat,
                           input int exp_busy);
    int lat = 0;
    int bcnt = 0;
    for (int k = k0; k <= 40; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy));
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; start = 1'b0; right = 1'b0; arith = 1'b0; amount = '0; D_in = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_D_out", D_out, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    reset = 1'b0;

    req(32'h0000_0001, 1'b0, 1'b0, 4);
    wait_done("left4", 1, 5, 4);
    check("left4_result", D_out, 32'h0000_0010);

    req(32'h8000_0000, 1'b1, 1'b0, 31);
    wait_done("lsr31", 1, 32, 31);
    check("lsr31_result", D_out, 32'h0000_0001);

    req(32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    wait_done("zero", 1, 1, 0);
    check("zero_result", D_out, 32'hDEAD_BEEF);

    // Start during SHIFT must be ignored.
    req(32'h0000_0003, 1'b0, 1'b0, 4);
    @(posedge clk); #1;
    D_in = 32'hFFFF_FFFF; amount = 5'd1; right = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignore", 3, 5, 2);
    check("ignore_result", D_out, 32'h0000_0030);

    // Back-to-back: accept in the DONE cycle.
    D_in = 32'h0000_0100; right = 1'b1; arith = 1'b0; amount = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b", 1, 3, 2);
    check("b2b_result", D_out, 32'h0000_0040);

    // Mid-shift reset.
    req(32'h0000_00A5, 1'b0, 1'b0, 8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_D_out", D_out, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 32'h0);

    req(32'h8000_0000, 1'b1, 1'b1, 4);
    wait_done("asr4", 1, 5, 4);
    check("asr4_result", D_out, ArithEn ? 32'hF800_0000 : 32'h0800_0000);
    check("asr4_sh_right", {31'b0, sh_right}, 32'h1);

    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      start  = ($urandom_range(3) == 0);
      D_in   = $urandom;
      right  = 1'($urandom_range(1));
      arith  = 1'($urandom_range(1));
      amount = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(5));
      reset  = ($urandom_range(99) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
